// File: rtl/rom_fetch_sequencer_pkg.sv
// Shared types and constants for the ROM fetch sequencer: FSM encoding,
// machine-cycle phase numbers and the default no-operation byte.
package rom_fetch_sequencer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } fetch_state_t;

  // Phase numbers within the 8-clock machine cycle
  localparam int PH_TMO   = 1;
  localparam int PH_HI    = 2;
  localparam int PH_LO    = 3;
  localparam int PH_LATCH = 4;

  localparam logic [7:0] NOP_BYTE = 8'h00;

  localparam int PC_HALF_W = 5;
  localparam int ADDR_W    = 2 * PC_HALF_W;
  localparam int DATA_W    = 8;

  function automatic logic [ADDR_W-1:0] rom_addr_join(
    input logic [PC_HALF_W-1:0] hi,
    input logic [PC_HALF_W-1:0] lo
  );
    return {hi, lo};
  endfunction

endpackage

// File: rtl/rom_fetch_sequencer_fetch_phase_gen.sv
// Machine-cycle phase counter, aligned to the core clock divider from reset.
// Decodes the PC half-select, the two address capture strobes and the REQ timeout.
module fetch_phase_gen
  import rom_fetch_sequencer_pkg::*;
#(
  parameter int PHASE_BITS = 3
) (
  input  logic clk,
  input  logic rst_n,
  output logic o_pc_mux,
  output logic o_cap_hi,
  output logic o_cap_lo,
  output logic o_tmo
);

  logic [PHASE_BITS-1:0] r_phase;

  // Free-running; wraps naturally at 2**PHASE_BITS
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_phase <= '0;
    end else begin
      r_phase <= r_phase + PHASE_BITS'(1);
    end
  end

  assign o_pc_mux = (r_phase == PHASE_BITS'(PH_HI));
  assign o_cap_hi = (r_phase == PHASE_BITS'(PH_HI));
  assign o_cap_lo = (r_phase == PHASE_BITS'(PH_LO));
  assign o_tmo    = (r_phase == PHASE_BITS'(PH_TMO));

endmodule

// File: rtl/rom_fetch_sequencer.sv
// Fetches one ROM byte per machine cycle for the core: address captured at phase 3,
// byte presented on instr at the following phase-3 edge (one machine cycle latency).
module rom_fetch_sequencer #(
  parameter logic [7:0] NOP_BYTE   = rom_fetch_sequencer_pkg::NOP_BYTE,
  parameter int         PHASE_BITS = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [4:0] pc_hl,
  output logic       pc_mux,
  output logic [9:0] rom_addr,
  output logic       rom_req,
  input  logic       rom_ack,
  input  logic [7:0] rom_data,
  output logic [7:0] instr,
  output logic       fetch_err
);

  import rom_fetch_sequencer_pkg::*;

  logic w_pc_mux;
  logic w_cap_hi;
  logic w_cap_lo;
  logic w_tmo;

  fetch_phase_gen #(
    .PHASE_BITS (PHASE_BITS)
  ) u_phase_gen (
    .clk      (clk),
    .rst_n    (rst_n),
    .o_pc_mux (w_pc_mux),
    .o_cap_hi (w_cap_hi),
    .o_cap_lo (w_cap_lo),
    .o_tmo    (w_tmo)
  );

  fetch_state_t r_state;
  fetch_state_t w_state_nxt;

  logic [4:0] r_addr_hi;
  logic [4:0] r_addr_hi_q;
  logic [4:0] r_addr_lo;
  logic [7:0] r_dbuf;
  logic [7:0] r_instr;
  logic       r_fetch_err;

  logic       w_dbuf_ld;
  logic [7:0] w_dbuf_dat;
  logic       w_err_set;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_dbuf_ld   = 1'b0;
    w_dbuf_dat  = NOP_BYTE;
    w_err_set   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_cap_lo) begin
          if (ena) begin
            w_state_nxt = REQ;
          end else begin
            w_dbuf_ld = 1'b1;
          end
        end
      end
      REQ: begin
        // An ack on the timeout edge still delivers its byte and leaves the flag alone
        if (rom_ack) begin
          w_dbuf_ld   = 1'b1;
          w_dbuf_dat  = rom_data;
          w_state_nxt = DONE;
        end else if (w_tmo) begin
          w_dbuf_ld   = 1'b1;
          w_err_set   = 1'b1;
          w_state_nxt = DONE;
        end
      end
      DONE: begin
        if (w_cap_lo) begin
          if (ena) begin
            w_state_nxt = REQ;
          end else begin
            w_dbuf_ld   = 1'b1;
            w_state_nxt = IDLE;
          end
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // The phase-3 edge both latches the new address and hands the previous byte to instr
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr_hi   <= '0;
      r_addr_hi_q <= '0;
      r_addr_lo   <= '0;
      r_dbuf      <= NOP_BYTE;
      r_instr     <= NOP_BYTE;
      r_fetch_err <= 1'b0;
    end else begin
      if (w_cap_hi) begin
        r_addr_hi <= pc_hl;
      end
      if (w_cap_lo) begin
        r_addr_lo   <= pc_hl;
        r_addr_hi_q <= r_addr_hi;
        r_instr     <= r_dbuf;
      end
      if (w_dbuf_ld) begin
        r_dbuf <= w_dbuf_dat;
      end
      if (w_err_set) begin
        r_fetch_err <= 1'b1;
      end
    end
  end

  assign pc_mux    = w_pc_mux;
  assign rom_addr  = rom_addr_join(r_addr_hi_q, r_addr_lo);
  assign rom_req   = (r_state == REQ);
  assign instr     = r_instr;
  assign fetch_err = r_fetch_err;

endmodule

// File: tb/tb_rom_fetch_sequencer.sv
// Directed bench for rom_fetch_sequencer; tracks the machine-cycle phase itself
// and checks outputs 1 ns after each rising edge.
module tb_rom_fetch_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic [4:0] pc_hl;
  logic       pc_mux;
  logic [9:0] rom_addr;
  logic       rom_req;
  logic       rom_ack;
  logic [7:0] rom_data;
  logic [7:0] instr;
  logic       fetch_err;

  int n_checks = 0;
  int n_err    = 0;
  int ph       = 0;

  always #5 clk = ~clk;

  rom_fetch_sequencer #(
    .NOP_BYTE   (8'h00),
    .PHASE_BITS (3)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ena       (ena),
    .pc_hl     (pc_hl),
    .pc_mux    (pc_mux),
    .rom_addr  (rom_addr),
    .rom_req   (rom_req),
    .rom_ack   (rom_ack),
    .rom_data  (rom_data),
    .instr     (instr),
    .fetch_err (fetch_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
    ph = (ph + 1) % 8;
  endtask

  task automatic goto_ph(input int p);
    for (int i = 0; i < 8 && ph != p; i++) tick();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n    = 1'b0;
    ena      = 1'b1;
    pc_hl    = 5'h00;
    rom_ack  = 1'b0;
    rom_data = 8'h00;
    repeat (3) tick();
    chk("rst_req",   rom_req,   1'b0);
    chk("rst_addr",  rom_addr,  10'h000);
    chk("rst_instr", instr,     8'h00);
    chk("rst_err",   fetch_err, 1'b0);
    chk("rst_mux",   pc_mux,    1'b0);
    rst_n = 1'b1;
    ph    = 0;

    // Basic fetch: address 3E5, ack on the second REQ clock with A5
    goto_ph(2);
    chk("a_mux_ph2", pc_mux, 1'b1);
    pc_hl = 5'h1F;
    tick();
    chk("a_mux_ph3", pc_mux, 1'b0);
    chk("a_req_ph3", rom_req, 1'b0);
    pc_hl = 5'h05;
    tick();
    chk("a_addr", rom_addr, 10'h3E5);
    chk("a_req_ph4", rom_req, 1'b1);
    tick();
    chk("a_req_ph5", rom_req, 1'b1);
    rom_ack  = 1'b1;
    rom_data = 8'hA5;
    tick();
    rom_ack  = 1'b0;
    rom_data = 8'h00;
    chk("a_req_drop", rom_req, 1'b0);
    chk("a_err", fetch_err, 1'b0);
    goto_ph(2);
    pc_hl = 5'h02;
    tick();
    chk("a_instr_early", instr, 8'h00);
    pc_hl = 5'h10;
    tick();
    chk("a_instr", instr, 8'hA5);
    chk("b_addr", rom_addr, 10'h050);
    chk("b_req_ph4", rom_req, 1'b1);

    // Ack coincides with the timeout edge: data wins, no error
    pc_hl = 5'h00;
    goto_ph(1);
    chk("b_req_ph1", rom_req, 1'b1);
    rom_ack  = 1'b1;
    rom_data = 8'h3C;
    tick();
    rom_ack  = 1'b0;
    rom_data = 8'h00;
    chk("b_req_drop", rom_req, 1'b0);
    chk("b_err", fetch_err, 1'b0);
    goto_ph(4);
    chk("b_instr", instr, 8'h3C);
    chk("b_err_ph4", fetch_err, 1'b0);

    // No ack at all: timeout after six REQ clocks
    tick();
    chk("c_req_ph5", rom_req, 1'b1);
    goto_ph(1);
    chk("c_req_ph1", rom_req, 1'b1);
    tick();
    chk("c_req_tmo", rom_req, 1'b0);
    chk("c_err_set", fetch_err, 1'b1);
    goto_ph(4);
    chk("c_instr_nop", instr, 8'h00);

    // Good fetch afterwards: error stays set
    tick();
    rom_ack  = 1'b1;
    rom_data = 8'h5A;
    tick();
    rom_ack  = 1'b0;
    rom_data = 8'h00;
    goto_ph(4);
    chk("d_instr", instr, 8'h5A);
    chk("d_err_sticky", fetch_err, 1'b1);

    // ena low for one machine cycle, with a spurious ack while idle
    tick();
    rom_ack  = 1'b1;
    rom_data = 8'h77;
    tick();
    rom_ack  = 1'b0;
    rom_data = 8'h00;
    goto_ph(3);
    ena = 1'b0;
    tick();
    chk("e_instr", instr, 8'h77);
    chk("e_no_req_ph4", rom_req, 1'b0);
    ena = 1'b1;
    goto_ph(6);
    chk("e_no_req_ph6", rom_req, 1'b0);
    rom_ack  = 1'b1;
    rom_data = 8'hFF;
    tick();
    rom_ack  = 1'b0;
    rom_data = 8'h00;
    chk("e_spur_instr", instr, 8'h77);
    goto_ph(1);
    chk("e_no_req_ph1", rom_req, 1'b0);
    goto_ph(4);
    chk("e_instr_nop", instr, 8'h00);
    chk("e_resume_req", rom_req, 1'b1);
    tick();
    rom_ack  = 1'b1;
    rom_data = 8'h88;
    tick();
    rom_ack  = 1'b0;
    rom_data = 8'h00;
    goto_ph(4);
    chk("e_resume_instr", instr, 8'h88);
    chk("f_req_ph4", rom_req, 1'b1);

    // Asynchronous reset in the middle of a request
    tick();
    #3;
    rst_n = 1'b0;
    #1;
    chk("f_rst_req", rom_req, 1'b0);
    chk("f_rst_instr", instr, 8'h00);
    chk("f_rst_err", fetch_err, 1'b0);
    chk("f_rst_addr", rom_addr, 10'h000);
    rom_ack  = 1'b1;
    rom_data = 8'hEE;
    tick();
    tick();
    rom_ack  = 1'b0;
    rom_data = 8'h00;
    rst_n = 1'b1;
    ph    = 0;
    chk("f_mux_ph0", pc_mux, 1'b0);
    goto_ph(2);
    chk("f_mux_ph2", pc_mux, 1'b1);
    goto_ph(3);
    chk("f_req_ph3", rom_req, 1'b0);
    tick();
    chk("f_req_first", rom_req, 1'b1);
    chk("f_instr_clean", instr, 8'h00);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/rom_fetch_sequencer.md
ROM_FETCH_SEQUENCER -- requirements
Module: rom_fetch_sequencer

Interface
REQ-001 Parameter NOP_BYTE, default 8'h00: byte presented on instr when no valid fetched byte is available.
REQ-002 Parameter PHASE_BITS, default 3: width of the machine-cycle phase counter (8 clocks per machine cycle).
REQ-003 clk  in  1  main clock; posedge effective; one clock and one reset only.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 ena  in  1  fetch enable; when low, no new ROM request is started.
REQ-006 pc_hl  in  5  multiplexed core PC: {PU,PL[5]} when pc_mux=1, PL[4:0] when pc_mux=0.
REQ-007 pc_mux  out  1  half-select driven to the core.
REQ-008 rom_addr  out  10  registered ROM address {PU,PL}.
REQ-009 rom_req  out  1  ROM read request, level.
REQ-010 rom_ack  in  1  ROM read acknowledge; rom_data valid in the same cycle.
REQ-011 rom_data  in  8  ROM byte.
REQ-012 instr  out  8  instruction byte to the core ROM input, registered.
REQ-013 fetch_err  out  1  sticky timeout flag.

Function
REQ-014 The 3-bit phase counter SHALL count 0..7 and wrap, advancing on every clk posedge; phase 0 is the cycle after reset release, aligned with the core clock divider.
REQ-015 pc_mux SHALL be 1 in phase 2 and 0 in every other phase.
REQ-016 At the end of phase 2, pc_hl SHALL be captured into addr_hi[4:0]; at the end of phase 3, pc_hl SHALL be captured into addr_lo[4:0].
REQ-017 rom_addr SHALL be updated to {addr_hi,addr_lo} at the end of phase 3 and held until the next such update.
REQ-018 FSM states: IDLE, REQ, DONE.
REQ-019 IDLE->REQ at the end of phase 3 when ena=1; rom_req=1 only in REQ.
REQ-020 In REQ, rom_ack=1 SHALL latch rom_data into the data buffer, drop rom_req on the next edge and move to DONE.
REQ-021 REQ timeout: if no ack has arrived by the end of phase 1 of the following machine cycle (6 clocks in REQ), the sequencer SHALL set fetch_err, load NOP_BYTE into the data buffer and go to DONE.
REQ-022 instr SHALL be loaded from the data buffer at the end of phase 3, one clock before the core latch edge at phase 4. Fetch latency is exactly one machine cycle from address capture.
REQ-023 DONE->REQ at the end of phase 3 when ena=1; otherwise DONE->IDLE.
REQ-024 When ena=0 at a phase-3 edge, the data buffer SHALL be loaded with NOP_BYTE, so that instr shows NOP_BYTE one machine cycle later.
REQ-025 If ack and timeout coincide on the same edge, ack SHALL win and fetch_err SHALL stay unchanged.
REQ-026 rom_ack outside REQ SHALL be ignored.
REQ-027 fetch_err SHALL clear only on reset.

Reset
REQ-028 Reset values: phase=0, state=IDLE, pc_mux=0, rom_req=0, rom_addr=0, addr_hi=addr_lo=0, data buffer=NOP_BYTE, instr=NOP_BYTE, fetch_err=0.
REQ-029 Reset asserted mid-request SHALL drop rom_req immediately (asynchronously), with no partial byte reaching instr.

Structure
REQ-030 The shared package SHALL hold the FSM state encoding, the phase constants PH_HI=2, PH_LO=3, PH_LATCH=4, and NOP_BYTE.
REQ-031 One sub-module, fetch_phase_gen, SHALL implement the phase counter and decode pc_mux, cap_hi, cap_lo and the timeout strobe; the FSM and registers stay in the top level.

Verification
REQ-032 pc_hl=5'h1F in phase 2 and 5'h05 in phase 3, ena=1, ack after 2 clocks with data 8'hA5 -> rom_addr=10'h3E5, rom_req high for 2 clocks, instr=8'hA5 from the next phase-3 edge.
REQ-033 ena=1, no ack ever -> rom_req drops after 6 clocks, fetch_err=1, instr=8'h00 at the next phase-3 edge, flag persists across later good fetches.
REQ-034 Ack on the same edge as the timeout, data 8'h3C -> instr=8'h3C, fetch_err=0.
REQ-035 ena low for one machine cycle -> no rom_req that cycle, instr=NOP_BYTE one machine cycle later, normal fetching resumes next cycle.
REQ-036 rst_n pulsed low while rom_req=1 -> all reset values hold immediately, phase restarts at 0, first rom_req appears at phase 4.
REQ-037 Spurious rom_ack in IDLE with data 8'hFF -> instr unchanged.
